// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one fixed-latency signed 8x8 Booth multiplier
// among NUM_REQ requesters; a tag pipeline routes each product back to its issuer.
module booth_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = 7,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_md_i,
  input  logic [NUM_REQ*8-1:0] req_mr_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           mul_md_o,
  output logic [7:0]           mul_mr_o,
  input  logic [15:0]          mul_result_i,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [15:0]          rsp_result_o,
  output logic                 busy_o
);

  localparam int unsigned     TagW    = $clog2(NUM_REQ);
  localparam int unsigned     Depth   = MUL_LAT + 1;
  localparam logic [3:0]      MaxOut  = 4'(MAX_OUT);
  localparam logic [TagW-1:0] LastIdx = TagW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_OUT < 1 || MAX_OUT > 15 || MUL_LAT < 1) begin : g_bad_param
    $error("booth_mul_arbiter: parameter out of range");
  end

  logic [TagW-1:0]             ptr_q, ptr_d;
  logic [NUM_REQ-1:0][3:0]     cnt_q, cnt_d;
  logic [Depth-1:0]            tag_vld_q, tag_vld_d;
  logic [Depth-1:0][TagW-1:0]  tag_q, tag_d;
  logic [7:0]                  md_q, md_d;
  logic [7:0]                  mr_q, mr_d;
  logic [NUM_REQ-1:0]          rsp_vld_q, rsp_vld_d;
  logic [15:0]                 rsp_res_q, rsp_res_d;

  logic [NUM_REQ-1:0]          elig;
  logic [NUM_REQ-1:0]          ready;
  logic [NUM_REQ-1:0]          inc;
  logic [NUM_REQ-1:0]          dec;
  logic                        grant_vld;
  logic [TagW-1:0]             grant_idx;
  logic [TagW:0]               cand;
  logic [TagW-1:0]             cand_idx;
  logic                        ret_vld;
  logic [TagW-1:0]             ret_tag;

  // Round-robin search from ptr; cand is one bit wider so the wrap is exact
  // for requester counts that are not a power of two.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < MaxOut);
    end
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + (TagW+1)'(off);
      if (cand >= (TagW+1)'(NUM_REQ)) begin
        cand = cand - (TagW+1)'(NUM_REQ);
      end
      cand_idx = cand[TagW-1:0];
      if (!grant_vld && elig[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
    ready = '0;
    if (grant_vld) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign ret_vld = tag_vld_q[Depth-1];
  assign ret_tag = tag_q[Depth-1];

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + TagW'(1);
    end

    md_d = '0;
    mr_d = '0;
    if (grant_vld) begin
      md_d = req_md_i[{grant_idx, 3'b000} +: 8];
      mr_d = req_mr_i[{grant_idx, 3'b000} +: 8];
    end

    tag_vld_d = {tag_vld_q[Depth-2:0], grant_vld};
    tag_d     = {tag_q[Depth-2:0], grant_idx};

    rsp_vld_d = '0;
    rsp_res_d = rsp_res_q;
    if (ret_vld) begin
      rsp_vld_d[ret_tag] = 1'b1;
      rsp_res_d          = mul_result_i;
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc[i]   = grant_vld && (grant_idx == TagW'(i));
      dec[i]   = ret_vld && (ret_tag == TagW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      tag_q     <= '0;
      md_q      <= '0;
      mr_q      <= '0;
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      tag_q     <= tag_d;
      md_q      <= md_d;
      mr_q      <= mr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_res_q <= rsp_res_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        assert (!(dec[i] && cnt_q[i] == 4'd0));
        assert (!(inc[i] && !dec[i] && cnt_q[i] == MaxOut));
      end
    end
  end

  assign req_ready_o  = ready;
  assign mul_md_o     = md_q;
  assign mul_mr_o     = mr_q;
  assign rsp_valid_o  = rsp_vld_q;
  assign rsp_result_o = rsp_res_q;
  assign busy_o       = (|tag_vld_q) | (|rsp_vld_q);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter; a behavioural fixed-latency multiplier
// is attached to the operand/result ports and responses are logged per cycle.
module tb_booth_mul_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 7;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [NR*8-1:0] req_md;
  logic [NR*8-1:0] req_mr;
  logic [7:0]      mul_md;
  logic [7:0]      mul_mr;
  logic [15:0]     mul_result;
  logic [15:0]     rsp_result;
  logic            busy;
  int              cyc    = 0;
  int              n_chk  = 0;
  int              n_pass = 0;

  booth_mul_arbiter #(.NUM_REQ(NR), .MUL_LAT(LAT), .MAX_OUT(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_md_i     (req_md),
    .req_mr_i     (req_mr),
    .req_ready_o  (req_ready),
    .mul_md_o     (mul_md),
    .mul_mr_o     (mul_mr),
    .mul_result_i (mul_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier: operands held in cycle c appear on the result in cycle c+LAT.
  logic [15:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {{8{mul_md[7]}}, mul_md} * {{8{mul_mr[7]}}, mul_mr};
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[LAT-1];

  typedef struct { int cyc; int idx; } gnt_t;
  typedef struct { int cyc; logic [NR-1:0] vec; logic [15:0] res; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) gq.push_back('{cyc, i});
      end
      if (rsp_valid != '0) rq.push_back('{cyc, rsp_valid, rsp_result});
    end
  end

  logic [7:0]  q_md [NR][8];
  logic [7:0]  q_mr [NR][8];
  int          q_n  [NR];
  int          q_i  [NR];
  int          e_idx [8];
  int          e_off [8];
  logic [15:0] e_res [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      q_n[i] = 0;
      q_i[i] = 0;
    end
    gq.delete();
    rq.delete();
  endtask

  task automatic load(input int i, input logic [7:0] md, input logic [7:0] mr);
    q_md[i][q_n[i]] = md;
    q_mr[i][q_n[i]] = mr;
    q_n[i]++;
  endtask

  task automatic set_exp(input int k, input int idx, input int off, input logic [15:0] res);
    e_idx[k] = idx;
    e_off[k] = off;
    e_res[k] = res;
  endtask

  // Each requester presents its queued operands in order, holding until granted.
  task automatic run(input int n);
    logic [NR-1:0] gnt;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (q_i[i] < q_n[i]) begin
          req_valid[i]      = 1'b1;
          req_md[i*8 +: 8]  = q_md[i][q_i[i]];
          req_mr[i*8 +: 8]  = q_mr[i][q_i[i]];
        end else begin
          req_valid[i]      = 1'b0;
          req_md[i*8 +: 8]  = '0;
          req_mr[i*8 +: 8]  = '0;
        end
      end
      #3;
      gnt = req_valid & req_ready;
      step();
      for (int i = 0; i < NR; i++) if (gnt[i]) q_i[i]++;
    end
  endtask

  task automatic check_stream(input string nm, input int n);
    check({nm, "_ngnt"}, gq.size(), n);
    check({nm, "_nrsp"}, rq.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < gq.size()) begin
        check($sformatf("%s_gidx%0d", nm, k), gq[k].idx, e_idx[k]);
        check($sformatf("%s_goff%0d", nm, k), gq[k].cyc - gq[0].cyc, e_off[k]);
      end
      if (k < rq.size()) begin
        check($sformatf("%s_rvec%0d", nm, k), rq[k].vec, 1 << e_idx[k]);
        check($sformatf("%s_rres%0d", nm, k), rq[k].res, e_res[k]);
        if (k < gq.size()) check($sformatf("%s_rlat%0d", nm, k), rq[k].cyc - gq[k].cyc, 9);
      end
    end
  endtask

  initial begin
    int rel;
    req_valid = '0;
    req_md    = '0;
    req_mr    = '0;
    clear_all();

    repeat (2) @(posedge clk);
    #3;
    check("rst_ready", req_ready, 0);
    check("rst_md", mul_md, 0);
    check("rst_mr", mul_mr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Single request: 0x05 * 0xFD = -15
    req_valid = 4'b0001;
    req_md[7:0] = 8'h05;
    req_mr[7:0] = 8'hFD;
    #3;
    check("s_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    #3;
    check("s_md", mul_md, 8'h05);
    check("s_mr", mul_mr, 8'hFD);
    check("s_busy1", busy, 1);
    check("s_rv1", rsp_valid, 0);
    for (int k = 2; k <= 10; k++) begin
      step();
      #3;
      check($sformatf("s_rv%0d", k), rsp_valid, (k == 9) ? 4'b0001 : 4'b0000);
      check($sformatf("s_busy%0d", k), busy, (k <= 9) ? 1 : 0);
      if (k == 2) begin
        check("s_bubble_md", mul_md, 0);
        check("s_bubble_mr", mul_mr, 0);
      end
      if (k == 8) check("s_res_hold0", rsp_result, 16'h0000);
      if (k >= 9) check($sformatf("s_res%0d", k), rsp_result, 16'hFFF1);
    end
    step();

    // Corner operands; ptr sits at 1 after the single grant to requester 0
    clear_all();
    load(0, 8'h80, 8'h80);
    load(1, 8'h7F, 8'h80);
    load(2, 8'h00, 8'hA5);
    set_exp(0, 1, 0, 16'hC080);
    set_exp(1, 2, 1, 16'h0000);
    set_exp(2, 0, 2, 16'h4000);
    run(14);
    check_stream("corner", 3);

    // All four busy, two requests each: rotation 1,2,3,0,1,2,3,0
    clear_all();
    load(0, 8'h03, 8'h04); load(0, 8'hFF, 8'hFF);
    load(1, 8'h02, 8'hFB); load(1, 8'h10, 8'h10);
    load(2, 8'h81, 8'h02); load(2, 8'h7F, 8'h7F);
    load(3, 8'hF0, 8'h10); load(3, 8'h0A, 8'hF6);
    set_exp(0, 1, 0, 16'hFFF6);
    set_exp(1, 2, 1, 16'hFF02);
    set_exp(2, 3, 2, 16'hFF00);
    set_exp(3, 0, 3, 16'h000C);
    set_exp(4, 1, 4, 16'h0100);
    set_exp(5, 2, 5, 16'h3F01);
    set_exp(6, 3, 6, 16'hFF9C);
    set_exp(7, 0, 7, 16'h0001);
    run(20);
    check_stream("rr", 8);

    // Credit limit of 2: regrant the cycle after each retirement
    clear_all();
    for (int k = 0; k < 6; k++) load(1, 8'h06, 8'h07);
    set_exp(0, 1, 0, 16'h002A);
    set_exp(1, 1, 1, 16'h002A);
    set_exp(2, 1, 9, 16'h002A);
    set_exp(3, 1, 10, 16'h002A);
    set_exp(4, 1, 18, 16'h002A);
    set_exp(5, 1, 19, 16'h002A);
    run(32);
    check_stream("cred", 6);

    // Five handshakes, reset mid-flight, then fresh traffic from ptr 0
    clear_all();
    load(0, 8'h01, 8'h01); load(0, 8'h02, 8'h02);
    load(1, 8'h03, 8'h03); load(1, 8'h04, 8'h04);
    load(3, 8'h05, 8'h05);
    set_exp(0, 3, 0, 0); set_exp(1, 0, 1, 0); set_exp(2, 1, 2, 0);
    set_exp(3, 0, 3, 0); set_exp(4, 1, 4, 0);
    run(5);
    check("pre_ngnt", gq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < gq.size()) check($sformatf("pre_gidx%0d", k), gq[k].idx, e_idx[k]);
    end
    run(3);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_md", mul_md, 0);
    check("mid_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    clear_all();
    load(1, 8'h0C, 8'hF3);
    load(3, 8'h05, 8'h05);
    set_exp(0, 1, 0, 16'hFF64);
    set_exp(1, 3, 1, 16'h0019);
    rst_n = 1'b1;
    rel = cyc;
    run(14);
    check("post_first_gnt", (gq.size() > 0) ? gq[0].cyc - rel : -1, 0);
    check_stream("post", 2);

    // Requester 2 withdraws while 0 is granted; 3 is next and idle drives zeros
    clear_all();
    req_valid = 4'b1101;
    req_md    = {8'h40, 8'h11, 8'h00, 8'hFE};
    req_mr    = {8'h04, 8'h11, 8'h00, 8'h03};
    #3;
    check("wd_ready0", req_ready, 4'b0001);
    step();
    req_valid = 4'b1000;
    #3;
    check("wd_ready1", req_ready, 4'b1000);
    check("wd_md0", mul_md, 8'hFE);
    check("wd_mr0", mul_mr, 8'h03);
    step();
    req_valid = '0;
    #3;
    check("wd_ready2", req_ready, 4'b0000);
    check("wd_md3", mul_md, 8'h40);
    check("wd_mr3", mul_mr, 8'h04);
    step();
    #3;
    check("wd_idle_md", mul_md, 8'h00);
    check("wd_idle_mr", mul_mr, 8'h00);
    step();
    set_exp(0, 0, 0, 16'hFFFA);
    set_exp(1, 3, 1, 16'h0100);
    run(10);
    check_stream("wd", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin front end that shares one pipelined 8x8 signed radix-4 Booth multiplier (`model_2` class, fixed latency, no valid/stall) among `NUM_REQ` requesters. It accepts operand pairs over valid/ready handshakes and issues at most one multiply per cycle. A valid/tag shift pipeline is kept aligned with the multiplier so each 16-bit product returns to the requester that issued it. Per-requester outstanding-credit counters bound in-flight work, and bubbles are driven as zero operands.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 7: clock edges from the multiplier sampling operands to the product appearing on its output register.
- `MAX_OUT`, default 4: maximum in-flight multiplies per requester, 1..15.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in `NUM_REQ`: request valid, one bit per requester.
- `req_md_i` in `NUM_REQ*8`: multiplicand; requester i occupies bits [8i+7:8i]; signed two's complement.
- `req_mr_i` in `NUM_REQ*8`: multiplier operand, same packing and signedness.
- `req_ready_o` out `NUM_REQ`: one-hot grant, combinational.
- `mul_md_o` out 8: registered multiplicand to the multiplier `MD_i`.
- `mul_mr_o` out 8: registered multiplier operand to the multiplier `MR_i`.
- `mul_result_i` in 16: multiplier `result_o`.
- `rsp_valid_o` out `NUM_REQ`: registered one-cycle, one-hot response strobe.
- `rsp_result_o` out 16: registered product; meaningful only while `rsp_valid_o` is non-zero.
- `busy_o` out 1: asserted while any multiply is in flight.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid_i[i]` is high and `cnt[i] < MAX_OUT`.
- **Arbitration.** Round-robin. The search starts at pointer `ptr` and wraps modulo `NUM_REQ`. The first eligible requester gets `req_ready_o[i]=1`. Handshake = valid & ready.
- **Pointer update.** On a handshake, `ptr` becomes `(i+1) mod NUM_REQ`. With no handshake, `ptr` holds.
- **Operand register.** On a handshake, `mul_md_o`/`mul_mr_o` load the granted operands. Otherwise they load 0x00/0x00 (bubble).
- **Request stability.** A requester must hold valid and operands stable until its handshake. Dropping valid before the handshake is legal and simply withdraws the request.
- **Tag pipeline.** Depth `MUL_LAT+1`, each stage = {valid, tag[clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {handshake, granted index} on the same edge as the operand register.
  - The pipeline shifts every cycle; there is no stall.
- **Response capture.** When the last stage is valid, the next edge registers `rsp_result_o <= mul_result_i` and sets `rsp_valid_o[tag]`. Otherwise `rsp_valid_o` is 0 and `rsp_result_o` holds its previous value.
- **No backpressure.** Responses have no backpressure; requesters must take the strobe.
- **Credit counters** (`cnt[i]`, 4 bits):
  - +1 on handshake of i.
  - −1 when the last tag stage retires a valid entry with tag i.
  - Both in the same cycle → unchanged.
  - Never exceeds `MAX_OUT` and never goes below 0; an underflow attempt is an assertion failure.
- **Busy.** `busy_o` = OR of all tag-stage valid bits and `rsp_valid_o`.
- **Arithmetic.** Product = signed(MD) × signed(MR) as 16 bits, computed by the multiplier. The arbiter does not modify it.

## Timing
- **Handshake to response.** A handshake in cycle t gives `rsp_valid_o` high in cycle t+`MUL_LAT`+2 (t+9 at default).
  - Edge 1 registers the operands.
  - The multiplier samples on the next edge.
  - `MUL_LAT` edges later the product is valid.
  - One more edge registers the response.
- **Throughput.** One handshake per cycle sustained, provided credits allow. Back-to-back responses can arrive on consecutive cycles, to the same or different requesters.
- **Reset values** (asynchronous, all immediate):
  - `req_ready_o`: combinational, 0 while no requester is valid.
  - `mul_md_o`, `mul_mr_o`: 0.
  - `rsp_valid_o`: 0.
  - `rsp_result_o`: 0x0000.
  - `busy_o`: 0.
  - `ptr`: 0; all `cnt`: 0; all tag valids: 0.
- **Reset mid-operation.** In-flight products are dropped because their tags are cleared. The multiplier's unreset datapath is ignored. No response is issued for pre-reset requests. The first handshake after reset release is granted in the first cycle `rst_ni` is sampled high.
- **Credit limit.** At `cnt[i]==MAX_OUT`, `req_ready_o[i]` is 0 in that same cycle. A retirement of i in cycle t raises the count margin from the following edge, so i can be granted in cycle t+1.

## Test plan
- Single request: req0, MD=0x05, MR=0xFD, one handshake at t → `rsp_valid_o=0001` only at t+9, `rsp_result_o=0xFFF1`. `busy_o` is high t+1..t+9.
- Corner values: MD=0x80, MR=0x80 → 0x4000. MD=0x7F, MR=0x80 → 0xC080. MD=0x00, MR=0xA5 → 0x0000.
- All four requesters valid continuously with distinct operands → grants rotate 0,1,2,3,0,… one per cycle, and responses return in grant order with correct tags and products.
- `MAX_OUT=2`, req1 alone, always valid → handshakes in cycles 0 and 1, ready low until the first retirement, then regrant the cycle after each retirement. `cnt` never reaches 3.
- Assert `rst_ni` low 3 cycles after 5 handshakes → no `rsp_valid_o` pulse ever appears for those 5. After release, a new request returns its correct product at +9.
- Requester 2 withdraws valid while requester 0 is granted, and requester 3 is valid → the next grant goes to 3 and `ptr` skips 2. Idle cycles drive `mul_md_o`/`mul_mr_o` to 0x00.
